// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed hex 7-segment driver for NUM_DIGITS common-anode digits.
//   Each refresh slot opens with an all-anodes-off gap, then drives one digit.
//   value/dp_in are captured into shadow registers only at a frame boundary,
//   so a change in the middle of a frame never tears the display.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     value       packed nibbles, digit 0 = bits 3:0 (rightmost)
//     dp_in       decimal point request per digit, active-high
//     update_en   capture enable, sampled only at a frame boundary
//     lz_en       leading-zero suppression, live (not shadowed)
//     segOut      segments a..g on bits 6..0, active-low
//     dpOut       decimal point, active-low
//     anode       digit enables, active-low, one-hot-low or all high
//     frame_tick  one-cycle pulse following each frame boundary

// Per-digit hex decode with an optional blank override.
module seg7_lane (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    unique case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    if (blank) seg = 7'b1111111;
  end
endmodule

module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    update_en,
  input  logic                    lz_en,
  output logic [6:0]              segOut,
  output logic                    dpOut,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_tick
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]             cnt;
  logic [IDX_W-1:0]             idx;
  logic [NUM_DIGITS-1:0][3:0]   shadow_val;
  logic [NUM_DIGITS-1:0]        shadow_dp;
  logic                         slot_end, frame_end, in_gap;
  logic [NUM_DIGITS-1:0]        lz_blank;
  logic [NUM_DIGITS-1:0][6:0]   dig_seg;
  logic [NUM_DIGITS-1:0]        anode_d;
  logic [6:0]                   seg_d;
  logic                         dp_d;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Gap compare only exists when a gap is configured; avoids a constant
  // unsigned "< 0" compare when BLANK_CYCLES is 0.
  generate
    if (BLANK_CYCLES > 0) begin : g_gap
      assign in_gap = (cnt < CNT_W'(BLANK_CYCLES));
    end else begin : g_nogap
      assign in_gap = 1'b0;
    end
  endgenerate

  // Prescaler, digit index and frame-synchronous shadow capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CNT_W'(1);
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      if (frame_end && update_en) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
    end
  end

  // A digit is suppressed when it and every digit above it are zero;
  // digit 0 is never suppressed so a zero value still shows "0".
  always_comb begin
    logic z;
    z = 1'b1;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      z = z & (shadow_val[k] == 4'h0);
      lz_blank[k] = lz_en & z & (k != 0);
    end
  end

  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
      seg7_lane u_lane (
        .nib   (shadow_val[k]),
        .blank (lz_blank[k]),
        .seg   (dig_seg[k])
      );
    end
  endgenerate

  always_comb begin
    anode_d = '1;
    seg_d   = 7'b1111111;
    dp_d    = 1'b1;
    if (!in_gap) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx == IDX_W'(k)) begin
          anode_d[k] = 1'b0;
          seg_d      = dig_seg[k];
          dp_d       = ~shadow_dp[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode      <= '1;
      segOut     <= 7'b1111111;
      dpOut      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      anode      <= anode_d;
      segOut     <= seg_d;
      dpOut      <= dp_d;
      frame_tick <= frame_end;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 8-cycle slots, 2-cycle gap).
// The stimulus process pushes the expected output of every cycle of each
// frame; the monitor pops and compares on every falling edge.
module tb_seg7_scan_driver;
  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          update_en;
  logic          lz_en;
  logic [6:0]    segOut;
  logic          dpOut;
  logic [3:0]    anode;
  logic          frame_tick;

  typedef struct {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .update_en  (update_en),
    .lz_en      (lz_en),
    .segOut     (segOut),
    .dpOut      (dpOut),
    .anode      (anode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: the display presents an output every cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("anode[c%0d]", e.cyc), 32'(anode), 32'(e.anode));
      chk($sformatf("seg[c%0d]", e.cyc), 32'(segOut), 32'(e.seg));
      chk($sformatf("dp[c%0d]", e.cyc), 32'(dpOut), 32'(e.dp));
      chk($sformatf("ftick[c%0d]", e.cyc), 32'(frame_tick), 32'(e.ft));
    end
  end

  // One full frame. segs = {d3,d2,d1,d0} expected digit patterns, dpm = digits
  // whose dp is expected lit. Inputs applied at the start are seen by every
  // edge of the frame (including its closing boundary); at mid_p value and
  // update_en switch to v1/upd1.
  int cyc = 0;
  task automatic frame(input logic [27:0] segs, input logic [3:0] dpm, input logic lz,
                       input logic [15:0] v0, input logic upd0, input logic [3:0] dp0,
                       input int mid_p, input logic [15:0] v1, input logic upd1);
    lz_en = lz; value = v0; update_en = upd0; dp_in = dp0;
    for (int p = 0; p < ND * RD; p++) begin
      exp_t e;
      int s, c;
      @(posedge clk); #1;
      s = p / RD; c = p % RD;
      e.cyc = cyc; cyc++;
      e.ft  = (p == ND * RD - 1);
      if (c < BC) begin
        e.anode = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
      end else begin
        e.anode = 4'b1111; e.anode[s] = 1'b0;
        e.seg   = segs[s*7 +: 7];
        e.dp    = ~dpm[s];
      end
      sb.push_back(e);
      if (p == mid_p) begin value = v1; update_en = upd1; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; value = '0; dp_in = '0; update_en = 1'b0; lz_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    value = 16'hFFFF; dp_in = 4'hF; update_en = 1'b1;
    repeat (13) @(posedge clk);
    // Mid-cycle asynchronous reset: outputs must drop immediately.
    #3 rst = 1'b1;
    #1;
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_seg", 32'(segOut), 32'h7F);
    chk("rst_dp", 32'(dpOut), 32'h1);
    chk("rst_ftick", 32'(frame_tick), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // F0: shadow discarded by reset -> all zeros; capture 3A7F at boundary.
    frame({4{7'b0000001}}, 4'b0000, 1'b0, 16'h3A7F, 1'b1, 4'h0, -1, 16'h0, 1'b0);
    // F1: shows 3A7F; value changes to 1234 mid-frame with capture enabled.
    frame({7'b0000110, 7'b0001000, 7'b0001111, 7'b0111000}, 4'b0000, 1'b0,
          16'h3A7F, 1'b1, 4'h0, 15, 16'h1234, 1'b1);
    // F2: shows 1234; update_en high only on non-boundary edges.
    frame({7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b0000, 1'b0,
          16'hFFFF, 1'b1, 4'h0, 20, 16'hFFFF, 1'b0);
    // F3: still 1234 (no leading zeros even with lz_en); capture 0050, dp2.
    frame({7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b0000, 1'b1,
          16'h0050, 1'b1, 4'b0100, -1, 16'h0, 1'b1);
    // F4: 0050 suppressed -> blank, blank, 5, 0; dp on blanked digit 2.
    frame({7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}, 4'b0100, 1'b1,
          16'h0000, 1'b1, 4'b0100, -1, 16'h0, 1'b1);
    // F5: value 0 with suppression -> only digit 0 lit.
    frame({7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b0100, 1'b1,
          16'h0000, 1'b0, 4'b0000, -1, 16'h0, 1'b0);
    // F6: lz_en dropped without a capture -> all digits show 0.
    frame({4{7'b0000001}}, 4'b0100, 1'b0,
          16'h0000, 1'b0, 4'b0000, -1, 16'h0, 1'b0);

    @(negedge clk); #1;
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
